// File: rtl/popcount_pkg.sv
// Shared helpers for the popcount accumulator: width math for the
// 3:2 compressor front end and the exact per-beat count.
package popcount_pkg;

    localparam int unsigned GRP_BITS = 3;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                r = unsigned'(i + 1);
            end
        end
        return r;
    endfunction

    function automatic int unsigned group_count(input int unsigned n_bits);
        return (n_bits + GRP_BITS - 1) / GRP_BITS;
    endfunction

    function automatic int unsigned padded_width(input int unsigned n_bits);
        return GRP_BITS * group_count(n_bits);
    endfunction

endpackage

// File: rtl/csa_layer.sv
// Combinational 3:2 compressor layer: one full adder per 3-bit group.
module csa_layer
    import popcount_pkg::*;
#(
    parameter int unsigned N_GRP = 5
) (
    input  logic [GRP_BITS*N_GRP-1:0] i_bits,
    output logic [N_GRP-1:0]          o_sum,
    output logic [N_GRP-1:0]          o_carry
);

    for (genvar g = 0; g < N_GRP; g++) begin : g_fa
        full_adder u_fa (
            .i_a     (i_bits[GRP_BITS*g]),
            .i_b     (i_bits[GRP_BITS*g+1]),
            .i_c     (i_bits[GRP_BITS*g+2]),
            .o_sum   (o_sum[g]),
            .o_carry (o_carry[g])
        );
    end

endmodule

// File: rtl/full_adder.sv
// One-bit full adder: three equal-weight inputs to a sum (weight 1) and carry (weight 2).
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_sum,
    output logic o_carry
);

    logic w_ab;

    assign w_ab    = i_a ^ i_b;
    assign o_sum   = w_ab ^ i_c;
    assign o_carry = (i_a & i_b) | (i_c & w_ab);

endmodule

// File: rtl/popcount_accum_pipe.sv
// Three-stage pipelined popcount with saturating per-frame accumulation
// and valid/ready flow control on both sides.
module popcount_accum_pipe
    import popcount_pkg::*;
#(
    parameter  int unsigned N_IN  = 15,
    parameter  int unsigned ACC_W = 16,
    localparam int unsigned CNT_W = clog2(N_IN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_bits,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_last,
    output logic             out_ovf
);

    localparam int unsigned N_GRP  = group_count(N_IN);
    localparam int unsigned N_PAD  = padded_width(N_IN);
    localparam int unsigned GCW    = clog2(N_GRP + 1);
    localparam int unsigned CNT_WX = CNT_W + 1;
    localparam int unsigned ACC_WX = ACC_W + 1;

    logic [N_PAD-1:0]  w_padded;
    logic [N_GRP-1:0]  w_sum;
    logic [N_GRP-1:0]  w_carry;

    logic              r_s1_valid;
    logic [N_GRP-1:0]  r_s1_sum;
    logic [N_GRP-1:0]  r_s1_carry;
    logic              r_s1_last;

    logic [GCW-1:0]    w_sum_cnt;
    logic [GCW-1:0]    w_car_cnt;
    logic              r_s2_valid;
    logic [GCW-1:0]    r_s2_sum_cnt;
    logic [GCW-1:0]    r_s2_car_cnt;
    logic              r_s2_last;

    logic [CNT_WX-1:0] w_beat_cnt_wide;
    logic [CNT_W-1:0]  w_beat_cnt;
    logic [ACC_WX-1:0] w_acc_sum;
    logic [ACC_W-1:0]  w_acc_sat;
    logic              w_ovf_next;

    logic              r_out_valid;
    logic [CNT_W-1:0]  r_out_count;
    logic [ACC_W-1:0]  r_out_acc;
    logic              r_out_last;
    logic              r_out_ovf;
    logic [ACC_W-1:0]  r_acc;
    logic              r_ovf;

    logic              w_s1_adv;
    logic              w_s2_adv;
    logic              w_s3_adv;

    // A stage may load when it is empty or its contents move on this cycle.
    assign w_s3_adv = !r_out_valid || out_ready;
    assign w_s2_adv = !r_s2_valid || w_s3_adv;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;

    assign w_padded = N_PAD'(in_bits);

    csa_layer #(
        .N_GRP (N_GRP)
    ) u_csa (
        .i_bits  (w_padded),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    // S1: compressor outputs, one sum/carry pair per group.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sum   <= '0;
            r_s1_carry <= '0;
            r_s1_last  <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sum   <= w_sum;
                r_s1_carry <= w_carry;
                r_s1_last  <= in_last;
            end
        end
    end

    always_comb begin
        w_sum_cnt = '0;
        w_car_cnt = '0;
        for (int g = 0; g < N_GRP; g++) begin
            w_sum_cnt = w_sum_cnt + GCW'(r_s1_sum[g]);
            w_car_cnt = w_car_cnt + GCW'(r_s1_carry[g]);
        end
    end

    // S2: separate counts of weight-1 sums and weight-2 carries.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid   <= 1'b0;
            r_s2_sum_cnt <= '0;
            r_s2_car_cnt <= '0;
            r_s2_last    <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_sum_cnt <= w_sum_cnt;
                r_s2_car_cnt <= w_car_cnt;
                r_s2_last    <= r_s1_last;
            end
        end
    end

    // One spare bit keeps the weighted add exact before narrowing to CNT_W.
    assign w_beat_cnt_wide = CNT_WX'(r_s2_sum_cnt) + (CNT_WX'(r_s2_car_cnt) << 1);
    assign w_beat_cnt      = CNT_W'(w_beat_cnt_wide);

    assign w_acc_sum  = ACC_WX'(r_acc) + ACC_WX'(w_beat_cnt);
    assign w_acc_sat  = w_acc_sum[ACC_W] ? {ACC_W{1'b1}} : w_acc_sum[ACC_W-1:0];
    assign w_ovf_next = r_ovf || w_acc_sum[ACC_W];

    // S3: result registers plus the frame accumulator, cleared after a last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_count <= '0;
            r_out_acc   <= '0;
            r_out_last  <= 1'b0;
            r_out_ovf   <= 1'b0;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
        end else if (w_s3_adv) begin
            r_out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_out_count <= w_beat_cnt;
                r_out_acc   <= w_acc_sat;
                r_out_last  <= r_s2_last;
                r_out_ovf   <= w_ovf_next;
                r_acc       <= r_s2_last ? '0 : w_acc_sat;
                r_ovf       <= r_s2_last ? 1'b0 : w_ovf_next;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_count = r_out_count;
    assign out_acc   = r_out_acc;
    assign out_last  = r_out_last;
    assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_popcount_accum_pipe.sv
// Randomized and directed bench for popcount_accum_pipe across three configurations,
// scored against a frame-level reference model.
module tb_popcount_accum_pipe;

    typedef struct {
        int cnt;
        int acc;
        bit last;
        bit ovf;
    } exp_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Instance 0: defaults; 1: narrow accumulator; 2: width not a multiple of 3.
    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int unsigned N = (k == 2) ? 8 : 15;
        localparam int unsigned A = (k == 1) ? 5 : 16;

        logic         in_valid;
        logic         in_ready;
        logic [N-1:0] in_bits;
        logic         in_last;
        logic         out_valid;
        logic         out_ready;
        logic [3:0]   out_count;
        logic [A-1:0] out_acc;
        logic         out_last;
        logic         out_ovf;

        exp_t q[$];

        popcount_accum_pipe #(
            .N_IN  (N),
            .ACC_W (A)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_bits   (in_bits),
            .in_last   (in_last),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_count (out_count),
            .out_acc   (out_acc),
            .out_last  (out_last),
            .out_ovf   (out_ovf)
        );

        // Reference: each accepted beat's popcount and saturating frame sum.
        initial begin
            int   m_acc;
            bit   m_ovf;
            bit   stall;
            exp_t held;
            exp_t e;
            int   sat_max;
            m_acc   = 0;
            m_ovf   = 0;
            stall   = 0;
            sat_max = (1 << A) - 1;
            forever begin
                @(negedge clk);
                if (rst) begin
                    q.delete();
                    m_acc = 0;
                    m_ovf = 0;
                    stall = 0;
                end else begin
                    if (stall) begin
                        check($sformatf("u%0d.hold_valid", k), int'(out_valid), 1);
                        check($sformatf("u%0d.hold_cnt", k), int'(out_count), held.cnt);
                        check($sformatf("u%0d.hold_acc", k), int'(out_acc), held.acc);
                        check($sformatf("u%0d.hold_last", k), int'(out_last), int'(held.last));
                    end
                    if (out_valid && out_ready) begin
                        if (q.size() == 0) begin
                            check($sformatf("u%0d.spurious_out", k), 1, 0);
                        end else begin
                            e = q.pop_front();
                            check($sformatf("u%0d.cnt", k), int'(out_count), e.cnt);
                            check($sformatf("u%0d.acc", k), int'(out_acc), e.acc);
                            check($sformatf("u%0d.last", k), int'(out_last), int'(e.last));
                            check($sformatf("u%0d.ovf", k), int'(out_ovf), int'(e.ovf));
                        end
                    end
                    if (in_valid && in_ready) begin
                        e.cnt  = $countones(in_bits);
                        e.acc  = m_acc + e.cnt;
                        e.ovf  = m_ovf;
                        e.last = in_last;
                        if (e.acc > sat_max) begin
                            e.acc = sat_max;
                            e.ovf = 1;
                        end
                        q.push_back(e);
                        m_acc = e.last ? 0 : e.acc;
                        m_ovf = e.last ? 0 : e.ovf;
                    end
                    stall     = out_valid && !out_ready;
                    held.cnt  = int'(out_count);
                    held.acc  = int'(out_acc);
                    held.last = out_last;
                end
            end
        end
    end

    task automatic drive(input int k, input logic v, input logic [14:0] b, input logic l);
        case (k)
            0: begin g_dut[0].in_valid = v; g_dut[0].in_bits = b; g_dut[0].in_last = l; end
            1: begin g_dut[1].in_valid = v; g_dut[1].in_bits = b; g_dut[1].in_last = l; end
            default: begin g_dut[2].in_valid = v; g_dut[2].in_bits = b[7:0]; g_dut[2].in_last = l; end
        endcase
    endtask

    task automatic set_oready(input int k, input logic r);
        case (k)
            0: g_dut[0].out_ready = r;
            1: g_dut[1].out_ready = r;
            default: g_dut[2].out_ready = r;
        endcase
    endtask

    function automatic logic get_ready(input int k);
        case (k)
            0: return g_dut[0].in_ready;
            1: return g_dut[1].in_ready;
            default: return g_dut[2].in_ready;
        endcase
    endfunction

    // Present a beat and hold it until accepted; returns just after the accepting edge.
    task automatic send(input int k, input logic [14:0] b, input logic l);
        logic r;
        int   n;
        drive(k, 1'b1, b, l);
        n = 0;
        do begin
            @(negedge clk);
            r = get_ready(k);
            @(posedge clk);
            #1;
            n++;
        end while (!r && n < 200);
        if (!r) check($sformatf("u%0d.send_timeout", k), 0, 1);
    endtask

    task automatic rand_run(input int k, input int n_beats);
        bit done;
        done = 0;
        fork
            begin
                for (int i = 0; i < n_beats; i++) begin
                    if ($urandom_range(0, 2) == 0) begin
                        drive(k, 1'b0, 15'($urandom), 1'b0);
                        @(posedge clk);
                        #1;
                    end
                    send(k, 15'($urandom), $urandom_range(0, 3) == 0);
                end
                drive(k, 1'b0, '0, 1'b0);
                done = 1;
            end
            begin
                while (!done) begin
                    set_oready(k, $urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
                set_oready(k, 1'b1);
            end
        join
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(k, 1'b0, '0, 1'b0);
            set_oready(k, 1'b1);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst.out_valid", int'(g_dut[0].out_valid), 0);
        check("rst.out_count", int'(g_dut[0].out_count), 0);
        check("rst.out_acc", int'(g_dut[0].out_acc), 0);
        check("rst.out_last", int'(g_dut[0].out_last), 0);
        check("rst.out_ovf", int'(g_dut[0].out_ovf), 0);
        check("rst.in_ready0", int'(g_dut[0].in_ready), 1);
        check("rst.in_ready1", int'(g_dut[1].in_ready), 1);
        check("rst.in_ready2", int'(g_dut[2].in_ready), 1);

        // Single full beat: result appears exactly three cycles after acceptance.
        @(posedge clk);
        #1;
        send(0, 15'h7FFF, 1'b1);
        drive(0, 1'b0, '0, 1'b0);
        @(negedge clk);
        check("lat.cycle1_valid", int'(g_dut[0].out_valid), 0);
        @(negedge clk);
        check("lat.cycle2_valid", int'(g_dut[0].out_valid), 0);
        @(negedge clk);
        check("lat.cycle3_valid", int'(g_dut[0].out_valid), 1);
        check("lat.count", int'(g_dut[0].out_count), 15);
        check("lat.acc", int'(g_dut[0].out_acc), 15);
        check("lat.last", int'(g_dut[0].out_last), 1);
        check("lat.ovf", int'(g_dut[0].out_ovf), 0);

        // Streaming frame followed back-to-back by a single-beat frame.
        @(posedge clk);
        #1;
        send(0, 15'h0001, 1'b0);
        send(0, 15'h00FF, 1'b0);
        send(0, 15'h5555, 1'b1);
        send(0, 15'h000F, 1'b1);
        drive(0, 1'b0, '0, 1'b0);
        repeat (6) @(posedge clk);
        #1;

        // Backpressure: consumer stalls for five cycles during a six-beat stream.
        set_oready(0, 1'b0);
        fork
            begin
                for (int i = 0; i < 6; i++) send(0, 15'($urandom), i == 5);
                drive(0, 1'b0, '0, 1'b0);
            end
            begin
                repeat (4) @(posedge clk);
                @(negedge clk);
                check("bp.in_ready_low", int'(g_dut[0].in_ready), 0);
                check("bp.out_valid", int'(g_dut[0].out_valid), 1);
                @(posedge clk);
                #1;
                set_oready(0, 1'b1);
            end
        join
        repeat (10) @(posedge clk);
        #1;

        // Reset with two beats in flight mid-frame.
        send(0, 15'h1234, 1'b0);
        send(0, 15'h0F0F, 1'b0);
        drive(0, 1'b0, '0, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rstmid.out_valid", int'(g_dut[0].out_valid), 0);
        end
        @(posedge clk);
        #1;
        send(0, 15'h0707, 1'b1);
        drive(0, 1'b0, '0, 1'b0);
        repeat (6) @(posedge clk);
        #1;

        // Narrow accumulator saturates on the third full beat, then recovers.
        send(1, 15'h7FFF, 1'b0);
        send(1, 15'h7FFF, 1'b0);
        send(1, 15'h7FFF, 1'b1);
        send(1, 15'h0003, 1'b1);
        drive(1, 1'b0, '0, 1'b0);
        repeat (6) @(posedge clk);
        #1;

        fork
            rand_run(0, 1000);
            rand_run(2, 1000);
        join
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("drain.q0", g_dut[0].q.size(), 0);
        check("drain.q1", g_dut[1].q.size(), 0);
        check("drain.q2", g_dut[2].q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
